// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: slice width and the serial
// subtractor state encoding.
package arith_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage : arith_pkg

// File: rtl/rca4.sv
// 4-bit ripple-carry slice adder: {Cout, resultOUT} = operA + operB + Cin.
module RCA4 (
  input  logic       Cin,
  input  logic [3:0] operA,
  input  logic [3:0] operB,
  output logic [3:0] resultOUT,
  output logic       Cout
);

  logic [4:0] sum_s;

  // Full 5-bit sum so the carry falls out as the top bit.
  always_comb begin
    sum_s = {1'b0, operA} + {1'b0, operB} + {4'b0000, Cin};
  end

  assign resultOUT = sum_s[3:0];
  assign Cout      = sum_s[4];

endmodule : RCA4

// File: rtl/rbs_serial_sub.sv
// Digit-serial ripple-borrow subtractor. Computes operA - operB - Bin one
// 4-bit slice per clock, LSB slice first, as A + ~B + ~Bin through a single
// RCA4 slice. Valid/ready handshake on both input and output sides.
module rbs_serial_sub
  import arith_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] operA,
  input  logic [N-1:0] operB,
  input  logic         Bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] resultOUT,
  output logic         Bout,
  output logic         zero,
  output logic         ovf
);

  localparam int SLICES = N / SLICE_W;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int SH_W   = CNT_W + 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLICES - 1);

  // Reject widths that do not split into whole slices.
  generate
    if ((N < SLICE_W) || ((N % SLICE_W) != 0)) begin : g_bad_width
      $error("rbs_serial_sub: N must be a multiple of 4 and >= 4");
    end
  endgenerate

  sub_state_t          state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                carry_r;
  logic [N-1:0]        a_r;
  logic [N-1:0]        b_r;

  logic [SH_W-1:0]     sh_s;
  logic [SLICE_W-1:0]  a_sl_s;
  logic [SLICE_W-1:0]  b_sl_s;
  logic [SLICE_W-1:0]  s_s;
  logic                c_next_s;
  logic [N-1:0]        slice_mask_s;
  logic [N-1:0]        res_next_s;

  // Select the current slice of each operand and splice the new slice
  // sum into the result word.
  always_comb begin
    sh_s         = SH_W'(cnt_r) * SH_W'(SLICE_W);
    a_sl_s       = SLICE_W'(a_r >> sh_s);
    b_sl_s       = SLICE_W'(b_r >> sh_s);
    slice_mask_s = N'({SLICE_W{1'b1}}) << sh_s;
    res_next_s   = (resultOUT & ~slice_mask_s) | (N'(s_s) << sh_s);
  end

  // Subtraction as A + ~B + carry, carry seeded with ~Bin.
  RCA4 u_rca4 (
    .Cin       (carry_r),
    .operA     (a_sl_s),
    .operB     (~b_sl_s),
    .resultOUT (s_s),
    .Cout      (c_next_s)
  );

  assign in_ready = (state_r == IDLE);

  // Control FSM, slice counter, operand capture and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      carry_r   <= 1'b0;
      a_r       <= {N{1'b0}};
      b_r       <= {N{1'b0}};
      out_valid <= 1'b0;
      resultOUT <= {N{1'b0}};
      Bout      <= 1'b0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= operA;
            b_r     <= operB;
            carry_r <= ~Bin;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= BUSY;
          end
        end
        BUSY: begin
          resultOUT <= res_next_s;
          carry_r   <= c_next_s;
          cnt_r     <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_CNT) begin
            Bout      <= ~c_next_s;
            ovf       <= (a_sl_s[SLICE_W-1] != b_sl_s[SLICE_W-1]) &&
                         (s_s[SLICE_W-1] != a_sl_s[SLICE_W-1]);
            zero      <= (res_next_s == {N{1'b0}});
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule : rbs_serial_sub

// File: tb/tb_rbs_serial_sub.sv
// Directed-vector bench for rbs_serial_sub (N=32).
module tb_rbs_serial_sub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operA;
  logic [31:0] operB;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] resultOUT;
  logic        Bout;
  logic        zero;
  logic        ovf;

  int vec_cnt;
  int miss_cnt;

  rbs_serial_sub #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operA     (operA),
    .operB     (operB),
    .Bin       (Bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .resultOUT (resultOUT),
    .Bout      (Bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Accept one operation and wait for out_valid; checks latency and flags.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic bin, input logic [31:0] exp_res, input logic exp_bout,
                       input logic exp_zero, input logic exp_ovf);
    int n;
    operA    = a;
    operB    = b;
    Bin      = bin;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    operA    = 32'hA5A5_A5A5;
    operB    = 32'h5A5A_5A5A;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, 32'd8);
    chk({tag, "_res"},  resultOUT, exp_res);
    chk({tag, "_bout"}, {31'd0, Bout}, {31'd0, exp_bout});
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
    chk({tag, "_ovf"},  {31'd0, ovf},  {31'd0, exp_ovf});
  endtask

  // Release a result held in DONE and confirm return to IDLE.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vec_cnt   = 0;
    miss_cnt  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operA     = 32'd0;
    operB     = 32'd0;
    Bin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res",   resultOUT, 32'd0);
    chk("rst_bout",  {31'd0, Bout}, 32'd0);
    chk("rst_zero",  {31'd0, zero}, 32'd0);
    chk("rst_ovf",   {31'd0, ovf}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_op("t1", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    drain("t1");
    do_op("t2", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    drain("t2");
    do_op("t3a", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    drain("t3a");
    do_op("t3b", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    drain("t3b");
    do_op("t4", 32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    drain("t4");

    // Backpressure: hold in DONE with a stray in_valid that must be ignored.
    do_op("t5", 32'h0000_0030, 32'h0000_0010, 1'b0, 32'h0000_0020, 1'b0, 1'b0, 1'b0);
    operA    = 32'hFFFF_FFFF;
    operB    = 32'h0000_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t5_hold_res",   resultOUT, 32'h0000_0020);
      chk("t5_hold_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    drain("t5");
    do_op("t5b", 32'h0000_0010, 32'h0000_0001, 1'b0, 32'h0000_000F, 1'b0, 1'b0, 1'b0);
    drain("t5b");

    // Reset in the middle of an operation.
    operA    = 32'hDEAD_BEEF;
    operB    = 32'h0000_0001;
    Bin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_res",   resultOUT, 32'd0);
    chk("t6_rst_bout",  {31'd0, Bout}, 32'd0);
    chk("t6_rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("t6_no_spurious", {31'd0, out_valid}, 32'd0);
    end
    do_op("t6", 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule : tb_rbs_serial_sub
